and_or_checker: RTL

AND_OR_CHECKER -- requirements
Module: and_or_checker

---
 rtl/and_or_checker.sv | 133 +++++++++++++
 1 files changed

// File: rtl/and_or_checker.sv
// and_or_checker: samples {a,b,c,d} for a programmed number of cycles and
// checks d == (a & b) | c one cycle later through a registered compare stage.
// Ports:
//   clk, rst (sync, active-high)
//   start, num_samples
//   a, b, c  stimulus bits
//   d        observed response
//   busy, done, pass
//   err_count, sample_count
//   first_err_valid, first_err_idx, first_err_vec
module and_or_checker #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [3:0]       first_err_vec
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_remaining;
    logic             r_stg_valid;
    logic [3:0]       r_stg_vec;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fvalid;
    logic [CNT_W-1:0] r_fidx;
    logic [3:0]       r_fvec;

    logic             w_exp;
    logic             w_mis;
    logic [ERR_W-1:0] w_err_nxt;

    // Stage vector layout is {a,b,c,d}
    assign w_exp = (r_stg_vec[3] & r_stg_vec[2]) | r_stg_vec[1];
    assign w_mis = r_stg_valid && (r_stg_vec[0] != w_exp);

    // Saturating error count, including the compare in flight this cycle
    assign w_err_nxt = (w_mis && (r_err != '1)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_stg_valid <= 1'b0;
            r_stg_vec   <= '0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_cnt       <= '0;
            r_fvalid    <= 1'b0;
            r_fidx      <= '0;
            r_fvec      <= '0;
        end else begin
            r_stg_valid <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_stg_vec <= {a, b, c, d};
            end

            if (r_stg_valid) begin
                r_cnt <= r_cnt + 1'b1;
                r_err <= w_err_nxt;
                if (w_mis && !r_fvalid) begin
                    r_fvalid <= 1'b1;
                    r_fidx   <= r_cnt;
                    r_fvec   <= r_stg_vec;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err    <= '0;
                        r_cnt    <= '0;
                        r_fvalid <= 1'b0;
                        r_fidx   <= '0;
                        r_fvec   <= '0;
                        if (num_samples == '0) begin
                            r_pass  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pass      <= 1'b0;
                            r_remaining <= num_samples;
                            r_state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Final compare lands this edge, so use the next count
                    r_pass  <= (w_err_nxt == '0);
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done            = (r_state == S_DONE);
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign sample_count    = r_cnt;
    assign first_err_valid = r_fvalid;
    assign first_err_idx   = r_fidx;
    assign first_err_vec   = r_fvec;

endmodule
